// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with early exit for divide corner cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_op_a,
  input  logic [XLEN-1:0] MD_op_b,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;

  // Accept-side decode: operand signedness, magnitudes and early-exit cases.
  logic            accept, signed_a, signed_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] mag_a, mag_b, spec_result;

  assign accept      = (state_q == IDLE) && MD_start;
  assign signed_a    = MD_funct3[2] ? ~MD_funct3[0] : ~(MD_funct3[1] & MD_funct3[0]);
  assign signed_b    = MD_funct3[2] ? ~MD_funct3[0] : ~MD_funct3[1];
  assign a_neg       = signed_a & MD_op_a[XLEN-1];
  assign b_neg       = signed_b & MD_op_b[XLEN-1];
  assign mag_a       = a_neg ? -MD_op_a : MD_op_a;
  assign mag_b       = b_neg ? -MD_op_b : MD_op_b;
  assign div_zero    = MD_funct3[2] && (MD_op_b == '0);
  assign div_ovf     = MD_funct3[2] && !MD_funct3[0] && (MD_op_a == MOST_NEG) && (MD_op_b == '1);
  assign special     = div_zero || div_ovf;
  assign spec_result = div_zero ? (MD_funct3[1] ? MD_op_a : '1)
                                : (MD_funct3[1] ? '0 : MD_op_a);
  // Remainder follows the dividend; everything else is the xor of signs.
  assign neg_in      = (MD_funct3[2] & MD_funct3[1]) ? a_neg : (a_neg ^ b_neg);

  // One iteration of the datapath. acc_q holds {product_hi, multiplier} for
  // multiply and {partial_remainder, dividend/quotient} for divide.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
    if (f3_q[2]) acc_step = {div_rem, acc_q[XLEN-2:0], div_ge};
    else         acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_comb begin
    prod_s = neg_q ? -acc_step : acc_step;
    quo_s  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_s  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (f3_q[2])              fin_result = f3_q[1] ? rem_s : quo_s;
    else if (f3_q[1:0] == '0) fin_result = prod_s[XLEN-1:0];
    else                      fin_result = prod_s[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge regardless of order.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MD_busy = (state_q != IDLE);
    MD_done = (state_q == DONE);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      f3_q      <= '0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      MD_result <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          f3_q  <= MD_funct3;
          cnt_q <= '0;
          neg_q <= neg_in;
          if (MD_funct3[2]) begin
            opnd_q <= mag_b;
            acc_q  <= {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd_q <= mag_a;
            acc_q  <= {{XLEN{1'b0}}, mag_b};
          end
          if (special) MD_result <= spec_result;
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) MD_result <= fin_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: XLEN=32 and XLEN=8 instances, a vector
// table driven through a scoreboard, plus start-flood and reset-abort sequences.
module tb_muldiv_unit;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        s_start, s8_start;
  logic [2:0]  s_f3, s8_f3;
  logic [31:0] s_a, s_b, res32;
  logic [7:0]  s8_a, s8_b, res8;
  logic        busy32, done32, busy8, done8;

  always #5 SYS_clk = ~SYS_clk;

  muldiv_unit #(.XLEN(32)) dut32 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .MD_start(s_start), .MD_funct3(s_f3),
    .MD_op_a(s_a), .MD_op_b(s_b), .MD_busy(busy32), .MD_done(done32), .MD_result(res32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .MD_start(s8_start), .MD_funct3(s8_f3),
    .MD_op_a(s8_a), .MD_op_b(s8_b), .MD_busy(busy8), .MD_done(done8), .MD_result(res8)
  );

  typedef struct {
    string       name;
    bit          w8;
    logic [2:0]  f3;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exp;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge SYS_clk);
    #1;
  endtask

  function automatic logic [63:0] cur_res(input bit w8);
    return w8 ? {56'b0, res8} : {32'b0, res32};
  endfunction

  function automatic logic cur_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      s8_start = st; s8_f3 = f3; s8_a = a[7:0]; s8_b = b[7:0];
    end else begin
      s_start = st; s_f3 = f3; s_a = a[31:0]; s_b = b[31:0];
    end
  endtask

  task automatic add(input string name, input bit w8, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat);
    vec_t v;
    v.name = name; v.w8 = w8; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one operation, scramble the inputs after accept, and wait for done.
  task automatic run_op(input vec_t v);
    logic [63:0] prev;
    int          cyc;
    bit          changed;
    exp_t        e;
    prev = cur_res(v.w8);
    drive(v.w8, 1'b1, v.f3, v.a, v.b);
    e.name = v.name; e.exp = v.exp; e.lat = v.lat;
    sb.push_back(e);
    tick;
    drive(v.w8, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    cyc = 1;
    changed = 1'b0;
    while (!cur_done(v.w8) && cyc < 60) begin
      if (cur_res(v.w8) !== prev) changed = 1'b1;
      tick;
      cyc++;
    end
    e = sb.pop_front();
    check({e.name, " done seen"}, 64'(cur_done(v.w8)), 64'd1);
    check({e.name, " result"}, cur_res(v.w8), e.exp);
    check({e.name, " latency"}, 64'(cyc), 64'(e.lat));
    check({e.name, " result held before done"}, 64'(changed), 64'd0);
    tick;
    check({e.name, " idle after done"}, {62'b0, cur_busy(v.w8), cur_done(v.w8)}, 64'd0);
    check({e.name, " result kept"}, cur_res(v.w8), e.exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   busy_cnt;
    exp_t e;

    add("mul -3*7",        0, 3'b000, 64'hFFFFFFFD, 64'h7,        64'hFFFFFFEB, 33);
    add("mulh -3*7",       0, 3'b001, 64'hFFFFFFFD, 64'h7,        64'hFFFFFFFF, 33);
    add("mulhsu -3*7",     0, 3'b010, 64'hFFFFFFFD, 64'h7,        64'hFFFFFFFF, 33);
    add("mulhu fffffffd*7",0, 3'b011, 64'hFFFFFFFD, 64'h7,        64'h00000006, 33);
    add("mulh minneg^2",   0, 3'b001, 64'h80000000, 64'h80000000, 64'h40000000, 33);
    add("mulhu max^2",     0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
    add("div -7/2",        0, 3'b100, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33);
    add("rem -7/2",        0, 3'b110, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33);
    add("div -7/-2",       0, 3'b100, 64'hFFFFFFF9, 64'hFFFFFFFE, 64'h00000003, 33);
    add("rem -7/-2",       0, 3'b110, 64'hFFFFFFF9, 64'hFFFFFFFE, 64'hFFFFFFFF, 33);
    add("divu 100/7",      0, 3'b101, 64'd100,      64'd7,        64'd14,       33);
    add("remu 100/7",      0, 3'b111, 64'd100,      64'd7,        64'd2,        33);
    add("divu max/10",     0, 3'b101, 64'hFFFFFFFF, 64'd10,       64'h19999999, 33);
    add("remu max/10",     0, 3'b111, 64'hFFFFFFFF, 64'd10,       64'd5,        33);
    add("div minneg/1",    0, 3'b100, 64'h80000000, 64'h1,        64'h80000000, 33);
    add("divu 5/0",        0, 3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 1);
    add("remu 5/0",        0, 3'b111, 64'd5,        64'd0,        64'd5,        1);
    add("div 7/0",         0, 3'b100, 64'd7,        64'd0,        64'hFFFFFFFF, 1);
    add("rem -7/0",        0, 3'b110, 64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 1);
    add("div overflow",    0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
    add("rem overflow",    0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1);
    add("x8 mulhsu",       1, 3'b010, 64'h80,       64'hFF,       64'h80,       9);
    add("x8 mul -3*7",     1, 3'b000, 64'hFD,       64'h07,       64'hEB,       9);
    add("x8 mulh -3*7",    1, 3'b001, 64'hFD,       64'h07,       64'hFF,       9);
    add("x8 div overflow", 1, 3'b100, 64'h80,       64'hFF,       64'h80,       1);
    add("x8 rem -7/2",     1, 3'b110, 64'hF9,       64'h02,       64'hFF,       9);

    SYS_reset = 1'b1;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    drive(1, 1'b0, 3'b000, 64'd0, 64'd0);
    tick;
    tick;
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset done32", 64'(done32), 64'd0);
    check("reset result32", 64'(res32), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset result8", 64'(res8), 64'd0);
    SYS_reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Start held high with fresh operands every cycle while a mul is running.
    drive(0, 1'b1, 3'b000, 64'd6, 64'd7);
    e.name = "start flood mul 6*7"; e.exp = 64'd42; e.lat = 33;
    sb.push_back(e);
    tick;
    cyc = 1;
    busy_cnt = 0;
    while (!done32 && cyc < 60) begin
      if (busy32) busy_cnt++;
      drive(0, 1'b1, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      tick;
      cyc++;
    end
    if (busy32) busy_cnt++;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    e = sb.pop_front();
    check({e.name, " done seen"}, 64'(done32), 64'd1);
    check({e.name, " result"}, 64'(res32), e.exp);
    check({e.name, " latency"}, 64'(cyc), 64'(e.lat));
    check({e.name, " busy cycles"}, 64'(busy_cnt), 64'd33);
    tick;
    check({e.name, " idle after"}, 64'(busy32), 64'd0);

    // Reset in the middle of a divide aborts it; start during reset is ignored.
    drive(0, 1'b1, 3'b100, 64'hFFFFFFF9, 64'd2);
    tick;
    drive(0, 1'b0, 3'b000, 64'd0, 64'd0);
    repeat (9) tick;
    check("div busy at cycle 10", 64'(busy32), 64'd1);
    SYS_reset = 1'b1;
    tick;
    check("abort busy", 64'(busy32), 64'd0);
    check("abort result", 64'(res32), 64'd0);
    check("abort done", 64'(done32), 64'd0);
    drive(0, 1'b1, 3'b000, 64'd5, 64'd5);
    tick;
    check("start during reset busy", 64'(busy32), 64'd0);
    check("start during reset done", 64'(done32), 64'd0);
    SYS_reset = 1'b0;
    begin
      vec_t v;
      v.name = "mul 3*4 after reset"; v.w8 = 0; v.f3 = 3'b000;
      v.a = 64'd3; v.b = 64'd4; v.exp = 64'd12; v.lat = 33;
      run_op(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 SYS_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SYS_reset  input  1  reset; synchronous and active-high.
REQ-004 MD_start  input  1  request; accepted only when MD_busy=0.
REQ-005 MD_funct3  input  3  RV M-extension funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-006 MD_op_a  input  XLEN  rs1 value, sampled at accept.
REQ-007 MD_op_b  input  XLEN  rs2 value, sampled at accept.
REQ-008 MD_busy  output  1  high whenever state is not IDLE.
REQ-009 MD_done  output  1  one-cycle pulse; MD_result valid that cycle.
REQ-010 MD_result  output  XLEN  result; held until the next accept.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, DONE; MD_busy=1 in CALC and DONE.
REQ-012 Accept: MD_start=1 while IDLE; on that edge capture funct3 and operands, and clear the cycle counter.
REQ-013 MD_start in CALC or DONE SHALL be ignored with no effect on the operation in progress.
REQ-014 Signed operands (mul/mulh/div/rem both; mulhsu op_a only) SHALL be converted to magnitudes at accept, and the result sign applied on the CALC->DONE transition.
REQ-015 Multiply: shift-add, one multiplier bit per cycle, 2*XLEN-bit product.
REQ-016 Multiply result selection: mul returns low XLEN bits; mulh, mulhsu and mulhu return high XLEN bits of the correctly signed product.
REQ-017 Divide: restoring, one quotient bit per cycle; div/divu return quotient, rem/remu return remainder.
REQ-018 Divide signs: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-019 CALC SHALL last exactly XLEN cycles, then DONE for exactly 1 cycle, then IDLE.
REQ-020 Normal latency: MD_done asserts in the XLEN+1-th cycle after the accept edge.
REQ-021 Divide by zero (op_b=0, funct3 1xx) SHALL skip CALC and go IDLE->DONE, with MD_done in the cycle after accept.
REQ-022 Divide by zero results: div/divu = all ones; rem/remu = op_a.
REQ-023 Signed overflow (div/rem, op_a=most-negative, op_b=all ones) SHALL skip CALC, with MD_done in the cycle after accept.
REQ-024 Signed overflow results: div = op_a; rem = 0.
REQ-025 MD_result SHALL update only on entry to DONE and be stable otherwise.
REQ-026 MD_start may be asserted in the cycle after DONE (IDLE); back-to-back issue gives one idle cycle between operations.
REQ-027 Operand changes after accept SHALL not affect the result.

Reset
REQ-028 SYS_reset=1 at an edge SHALL force state IDLE, MD_busy=0, MD_done=0, MD_result=0, counter=0, and clear all operand/accumulator registers.
REQ-029 Reset mid-CALC or in DONE SHALL abort with no MD_done pulse.
REQ-030 MD_start asserted together with SYS_reset SHALL be ignored.
REQ-031 Operation starts are accepted from the first edge after SYS_reset deasserts.

Verification
REQ-032 XLEN=32, mul op_a=0xFFFFFFFD (-3), op_b=7 -> MD_done at cycle 33 after accept; MD_result=0xFFFFFFEB; mulh with same operands -> 0xFFFFFFFF; mulhu -> 0x00000006.
REQ-033 div op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 100/7 -> 14; remu -> 2; each at cycle 33.
REQ-034 divu op_a=5, op_b=0 -> MD_done 1 cycle after accept, MD_result=0xFFFFFFFF; remu -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle; rem -> 0.
REQ-035 MD_start pulsed with new operands every cycle during a mul of 6*7 -> only the first is accepted; MD_result=42; MD_busy contiguous 33 cycles.
REQ-036 SYS_reset asserted at cycle 10 of a div -> next cycle MD_busy=0, MD_result=0; no MD_done; a fresh mul 3*4 then returns 12.
REQ-037 XLEN=8 instance: mulhsu op_a=0x80 (-128), op_b=0xFF (255) -> 0x80; done at cycle 9.
